// File: rtl/lcd_text_streamer_pkg.sv
// Shared constants, opcodes and state types for the lcd16x2 text front end.
package lcd16x2_pkg;

  localparam logic [1:0] OPS_CMD  = 2'd0;
  localparam logic [1:0] OPS_DATA = 2'd1;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_FF = 8'h0C;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  // What the transaction in flight does to the cursor once lcd16x2 completes it.
  typedef enum logic [2:0] {
    KIND_DATA = 3'd0,
    KIND_WRAP = 3'd1,
    KIND_LF   = 3'd2,
    KIND_CR   = 3'd3,
    KIND_FF   = 3'd4
  } kind_e;

  function automatic logic [7:0] ddram_cmd(input logic [7:0] base);
    return CMD_SET_DDRAM | base;
  endfunction

endpackage

// File: rtl/lcd_text_streamer_fifo.sv
// Single-clock byte FIFO feeding the text streamer; pointers wrap modulo DEPTH.
module lcd_text_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Storage is not reset: clearing the pointers makes stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_streamer.sv
// Streams buffered ASCII bytes into lcd16x2, tracking the cursor and wrapping lines.
// Define LCD_TEXT_CTRL_EN to issue LF/CR/FF as cursor commands instead of data.
module lcd_text_streamer
  import lcd16x2_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter int         COLS       = 16,
  parameter logic [7:0] LINE1_ADDR = 8'h40
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    s_data_i,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  output logic [7:0]                    lcd_data_o,
  output logic [1:0]                    lcd_ops_o,
  output logic                          lcd_enb_o,
  output logic                          lcd_rst_o,
  input  logic                          lcd_rdy_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          busy_o
);

  localparam int               COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       ops_q, ops_d;
  logic             enb_q, enb_d;
  logic             lcd_rst_q;
  logic [COL_W-1:0] col_q, col_d;
  logic             line_q, line_d;
  logic             wrap_pend_q, wrap_pend_d;
  logic [7:0]       wrap_cmd_q, wrap_cmd_d;

  logic [7:0]       fifo_head_s;
  logic             fifo_full_s, fifo_empty_s;
  logic             push_s, pop_s;

  assign s_ready_o  = rst_ni && !lcd_rst_q && !fifo_full_s;
  assign push_s     = s_valid_i && s_ready_o;
  assign lcd_data_o = data_q;
  assign lcd_ops_o  = ops_q;
  assign lcd_enb_o  = enb_q;
  assign lcd_rst_o  = lcd_rst_q;
  assign busy_o     = !fifo_empty_s || (state_q != ST_IDLE) || wrap_pend_q;

  lcd_text_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .data_i  (s_data_i),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_o)
  );

  // One-cycle re-initialisation pulse towards lcd16x2 after every reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lcd_rst_q <= 1'b1;
    else         lcd_rst_q <= 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    data_d      = data_q;
    ops_d       = ops_q;
    enb_d       = enb_q;
    col_d       = col_q;
    line_d      = line_q;
    wrap_pend_d = wrap_pend_q;
    wrap_cmd_d  = wrap_cmd_q;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wrap_pend_q && lcd_rdy_i) begin
          data_d      = wrap_cmd_q;
          ops_d       = OPS_CMD;
          kind_d      = KIND_WRAP;
          enb_d       = 1'b1;
          wrap_pend_d = 1'b0;
          state_d     = ST_WAIT_ACK;
        end else if (!fifo_empty_s && lcd_rdy_i) begin
          pop_s   = 1'b1;
          data_d  = fifo_head_s;
          ops_d   = OPS_DATA;
          kind_d  = KIND_DATA;
          enb_d   = 1'b1;
          state_d = ST_WAIT_ACK;
`ifdef LCD_TEXT_CTRL_EN
          case (fifo_head_s)
            CHAR_LF: begin
              data_d = ddram_cmd(line_q ? 8'h00 : LINE1_ADDR);
              ops_d  = OPS_CMD;
              kind_d = KIND_LF;
            end
            CHAR_CR: begin
              data_d = ddram_cmd(line_q ? LINE1_ADDR : 8'h00);
              ops_d  = OPS_CMD;
              kind_d = KIND_CR;
            end
            CHAR_FF: begin
              data_d = CMD_CLEAR;
              ops_d  = OPS_CMD;
              kind_d = KIND_FF;
            end
            default: kind_d = KIND_DATA;
          endcase
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_ACK: begin
        if (!lcd_rdy_i) begin
          enb_d   = 1'b0;
          state_d = ST_WAIT_DONE;
        end else begin
          enb_d   = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (lcd_rdy_i) begin
          state_d = ST_IDLE;
          // Cursor moves only once lcd16x2 has finished the transaction.
          case (kind_q)
            KIND_DATA: begin
              if (col_q == COL_LAST) begin
                col_d       = {COL_W{1'b0}};
                line_d      = !line_q;
                wrap_pend_d = 1'b1;
                wrap_cmd_d  = ddram_cmd(line_q ? 8'h00 : LINE1_ADDR);
              end else begin
                col_d       = col_q + COL_W'(1);
              end
            end
            KIND_LF: begin
              col_d  = {COL_W{1'b0}};
              line_d = !line_q;
            end
            KIND_CR: col_d = {COL_W{1'b0}};
            KIND_FF: begin
              col_d  = {COL_W{1'b0}};
              line_d = 1'b0;
            end
            default: col_d = col_q;
          endcase
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        enb_d   = 1'b0;
      end
    endcase
  end

  // FSM, output and cursor registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      kind_q      <= KIND_DATA;
      data_q      <= 8'h00;
      ops_q       <= OPS_CMD;
      enb_q       <= 1'b0;
      col_q       <= {COL_W{1'b0}};
      line_q      <= 1'b0;
      wrap_pend_q <= 1'b0;
      wrap_cmd_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      data_q      <= data_d;
      ops_q       <= ops_d;
      enb_q       <= enb_d;
      col_q       <= col_d;
      line_q      <= line_d;
      wrap_pend_q <= wrap_pend_d;
      wrap_cmd_q  <= wrap_cmd_d;
    end
  end

endmodule
